// File: rtl/asteroides_pkg.sv
// Shared definitions for the asteroid game control path.
// Holds the FSM state codes, which the hex display decoder and the benches also use.
package asteroides_pkg;

    localparam int unsigned ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] ST_INICIAL     = 4'h0;
    localparam logic [ESTADO_W-1:0] ST_PREPARA     = 4'h1;
    localparam logic [ESTADO_W-1:0] ST_ESPERA      = 4'h2;
    localparam logic [ESTADO_W-1:0] ST_CALC_X      = 4'h3;
    localparam logic [ESTADO_W-1:0] ST_SALVA_X     = 4'h4;
    localparam logic [ESTADO_W-1:0] ST_CALC_Y      = 4'h5;
    localparam logic [ESTADO_W-1:0] ST_SALVA_Y     = 4'h6;
    localparam logic [ESTADO_W-1:0] ST_VERIFICA    = 4'h7;
    localparam logic [ESTADO_W-1:0] ST_PERDE_VIDA  = 4'h8;
    localparam logic [ESTADO_W-1:0] ST_CHECA_VIDAS = 4'h9;
    localparam logic [ESTADO_W-1:0] ST_RESPAWN     = 4'hA;
    localparam logic [ESTADO_W-1:0] ST_FIM         = 4'hB;

endpackage

// File: rtl/unidade_controle_asteroide_contador_passo.sv
// Step-delay counter: counts 0..PASSO_CICLOS-1 while enabled.
// fim is high on the last count.
module contador_passo #(
    parameter int unsigned PASSO_CICLOS = 50_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int unsigned CNT_W = $clog2(PASSO_CICLOS + 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PASSO_CICLOS - 1);

    logic [CNT_W-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable) begin
            if (contagem == ULTIMO) contagem <= '0;
            else                    contagem <= contagem + CNT_W'(1);
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_asteroide.sv
// Control FSM for the asteroid datapath: timed X/Y moves, collision/hit check,
// life decrement and end of game. Outputs are Moore-decoded from the state register.
module unidade_controle_asteroide
    import asteroides_pkg::*;
#(
    parameter int unsigned PASSO_CICLOS = 50_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       dir_x,
    input  logic       dir_y,
    input  logic       velocidade,
    input  logic       colisao,
    input  logic       acertou,
    input  logic       vidas,
    output logic       clear_reg_asteroide,
    output logic       enable_reg_asteroide_x,
    output logic       enable_reg_asteroide_y,
    output logic       select_mux_coor,
    output logic       select_mux_incremento,
    output logic       select_sum_sub,
    output logic       clear_decrementer,
    output logic       load_decrementer,
    output logic       ent_decrementer,
    output logic       pronto,
    output logic       fim_jogo,
    output logic [3:0] db_estado
);

    logic [ESTADO_W-1:0] estado;
    logic [ESTADO_W-1:0] proximo;
    logic                fim_passo;
    logic                dir_x_r;
    logic                dir_y_r;
    logic                vel_r;
    logic                em_espera;

    assign em_espera = (estado == ST_ESPERA);

    contador_passo #(
        .PASSO_CICLOS(PASSO_CICLOS)
    ) u_contador_passo (
        .clock (clock),
        .reset (reset),
        .clear (!em_espera),
        .enable(em_espera),
        .fim   (fim_passo)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= ST_INICIAL;
        else        estado <= proximo;
    end

    // Direction/speed frozen for the whole move sequence
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_x_r <= 1'b0;
            dir_y_r <= 1'b0;
            vel_r   <= 1'b0;
        end else if (em_espera && fim_passo) begin
            dir_x_r <= dir_x;
            dir_y_r <= dir_y;
            vel_r   <= velocidade;
        end
    end

    // Next-state logic
    always_comb begin
        proximo = ST_INICIAL;
        case (estado)
            ST_INICIAL:     proximo = iniciar ? ST_PREPARA : ST_INICIAL;
            ST_PREPARA:     proximo = ST_ESPERA;
            ST_ESPERA:      proximo = fim_passo ? ST_CALC_X : ST_ESPERA;
            ST_CALC_X:      proximo = ST_SALVA_X;
            ST_SALVA_X:     proximo = ST_CALC_Y;
            ST_CALC_Y:      proximo = ST_SALVA_Y;
            ST_SALVA_Y:     proximo = ST_VERIFICA;
            ST_VERIFICA: begin
                if (colisao)      proximo = ST_PERDE_VIDA;
                else if (acertou) proximo = ST_RESPAWN;
                else              proximo = ST_ESPERA;
            end
            ST_PERDE_VIDA:  proximo = ST_CHECA_VIDAS;
            ST_CHECA_VIDAS: proximo = vidas ? ST_RESPAWN : ST_FIM;
            ST_RESPAWN:     proximo = ST_ESPERA;
            ST_FIM:         proximo = iniciar ? ST_PREPARA : ST_FIM;
            default:        proximo = ST_INICIAL;
        endcase
    end

    // Output decode
    always_comb begin
        clear_reg_asteroide    = 1'b0;
        enable_reg_asteroide_x = 1'b0;
        enable_reg_asteroide_y = 1'b0;
        select_mux_coor        = 1'b0;
        select_mux_incremento  = 1'b0;
        select_sum_sub         = 1'b0;
        clear_decrementer      = 1'b0;
        load_decrementer       = 1'b0;
        ent_decrementer        = 1'b0;
        pronto                 = 1'b0;
        fim_jogo               = 1'b0;
        case (estado)
            ST_INICIAL: begin
                pronto            = 1'b1;
                clear_decrementer = 1'b1;
            end
            ST_PREPARA: begin
                clear_reg_asteroide = 1'b1;
                load_decrementer    = 1'b1;
            end
            ST_CALC_X: begin
                select_mux_incremento = vel_r;
                select_sum_sub        = dir_x_r;
            end
            ST_SALVA_X: begin
                select_mux_incremento  = vel_r;
                select_sum_sub         = dir_x_r;
                enable_reg_asteroide_x = 1'b1;
            end
            ST_CALC_Y: begin
                select_mux_coor       = 1'b1;
                select_mux_incremento = vel_r;
                select_sum_sub        = dir_y_r;
            end
            ST_SALVA_Y: begin
                select_mux_coor        = 1'b1;
                select_mux_incremento  = vel_r;
                select_sum_sub         = dir_y_r;
                enable_reg_asteroide_y = 1'b1;
            end
            ST_PERDE_VIDA: ent_decrementer     = 1'b1;
            ST_RESPAWN:    clear_reg_asteroide = 1'b1;
            ST_FIM:        fim_jogo            = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_asteroide.sv
// Directed bench for unidade_controle_asteroide with a 4-cycle step delay.
// Outputs are packed as {clr_reg, en_x, en_y, coor, inc, sub, clr_dec, load_dec, ent_dec, pronto, fim}.
module tb_unidade_controle_asteroide;
    import asteroides_pkg::*;

    localparam int unsigned PASSO = 4;

    localparam logic [10:0] O_NADA    = 11'b000_000_000_00;
    localparam logic [10:0] O_INICIAL = 11'b000_000_100_10;
    localparam logic [10:0] O_PREPARA = 11'b100_000_010_00;
    localparam logic [10:0] O_RESPAWN = 11'b100_000_000_00;
    localparam logic [10:0] O_PERDE   = 11'b000_000_001_00;
    localparam logic [10:0] O_FIM     = 11'b000_000_000_01;

    logic clock = 1'b0;
    logic reset, iniciar, dir_x, dir_y, velocidade, colisao, acertou, vidas;
    logic clear_reg_asteroide, enable_reg_asteroide_x, enable_reg_asteroide_y;
    logic select_mux_coor, select_mux_incremento, select_sum_sub;
    logic clear_decrementer, load_decrementer, ent_decrementer, pronto, fim_jogo;
    logic [3:0] db_estado;
    logic [10:0] saidas;

    int n_cmp = 0;
    int n_err = 0;

    unidade_controle_asteroide #(.PASSO_CICLOS(PASSO)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .iniciar               (iniciar),
        .dir_x                 (dir_x),
        .dir_y                 (dir_y),
        .velocidade            (velocidade),
        .colisao               (colisao),
        .acertou               (acertou),
        .vidas                 (vidas),
        .clear_reg_asteroide   (clear_reg_asteroide),
        .enable_reg_asteroide_x(enable_reg_asteroide_x),
        .enable_reg_asteroide_y(enable_reg_asteroide_y),
        .select_mux_coor       (select_mux_coor),
        .select_mux_incremento (select_mux_incremento),
        .select_sum_sub        (select_sum_sub),
        .clear_decrementer     (clear_decrementer),
        .load_decrementer      (load_decrementer),
        .ent_decrementer       (ent_decrementer),
        .pronto                (pronto),
        .fim_jogo              (fim_jogo),
        .db_estado             (db_estado)
    );

    always #5 clock = ~clock;

    assign saidas = {clear_reg_asteroide, enable_reg_asteroide_x, enable_reg_asteroide_y,
                     select_mux_coor, select_mux_incremento, select_sum_sub,
                     clear_decrementer, load_decrementer, ent_decrementer, pronto, fim_jogo};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] est_exp, input logic [10:0] out_exp);
        n_cmp++;
        assert (db_estado === est_exp && saidas === out_exp) else begin
            n_err++;
            $error("FAIL %s: observed estado=%0h saidas=%b expected estado=%0h saidas=%b",
                   tag, db_estado, saidas, est_exp, out_exp);
        end
    endtask

    // From the first ESPERA cycle, advance to the VERIFICA state
    task automatic ate_verifica();
        for (int i = 0; i < int'(PASSO) + 4; i++) tick();
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; dir_x = 1'b0; dir_y = 1'b0; velocidade = 1'b0;
        colisao = 1'b0; acertou = 1'b0; vidas = 1'b1;
        tick(); tick();
        chk("reset", ST_INICIAL, O_INICIAL);
        reset = 1'b1;
        tick();
        chk("idle", ST_INICIAL, O_INICIAL);

        // Test 1: basic step timing
        iniciar = 1'b1;
        tick();
        chk("prepara", ST_PREPARA, O_PREPARA);
        iniciar = 1'b0;
        for (int i = 0; i < int'(PASSO); i++) begin
            tick();
            chk("espera", ST_ESPERA, O_NADA);
        end
        tick(); chk("calc_x", ST_CALC_X, O_NADA);
        tick(); chk("salva_x", ST_SALVA_X, 11'b010_000_000_00);
        tick(); chk("calc_y", ST_CALC_Y, 11'b000_100_000_00);
        tick(); chk("salva_y", ST_SALVA_Y, 11'b001_100_000_00);
        dir_x = 1'b1; velocidade = 1'b1;
        tick(); chk("verifica", ST_VERIFICA, O_NADA);

        // Test 2: captured direction survives input change
        tick(); chk("espera2", ST_ESPERA, O_NADA);
        for (int i = 0; i < int'(PASSO); i++) tick();
        chk("calc_x_cap", ST_CALC_X, 11'b000_011_000_00);
        dir_x = 1'b0; velocidade = 1'b0;
        tick(); chk("salva_x_cap", ST_SALVA_X, 11'b010_011_000_00);
        tick(); chk("calc_y_cap", ST_CALC_Y, 11'b000_110_000_00);
        tick(); chk("salva_y_cap", ST_SALVA_Y, 11'b001_110_000_00);

        // Test 3: collision with lives remaining
        colisao = 1'b1; vidas = 1'b1;
        tick(); chk("verifica_col", ST_VERIFICA, O_NADA);
        tick(); chk("perde_vida", ST_PERDE_VIDA, O_PERDE);
        colisao = 1'b0;
        tick(); chk("checa_vidas", ST_CHECA_VIDAS, O_NADA);
        tick(); chk("respawn", ST_RESPAWN, O_RESPAWN);
        tick(); chk("espera_pos_respawn", ST_ESPERA, O_NADA);

        // Shot hit only -> respawn
        ate_verifica();
        chk("verifica_hit", ST_VERIFICA, O_NADA);
        acertou = 1'b1;
        tick(); chk("hit_respawn", ST_RESPAWN, O_RESPAWN);
        acertou = 1'b0;
        tick(); chk("hit_espera", ST_ESPERA, O_NADA);

        // Test 5 and 4: collision wins over hit, then last life lost
        ate_verifica();
        colisao = 1'b1; acertou = 1'b1;
        tick(); chk("col_prioridade", ST_PERDE_VIDA, O_PERDE);
        colisao = 1'b0; acertou = 1'b0; vidas = 1'b0;
        tick(); chk("checa_sem_vidas", ST_CHECA_VIDAS, O_NADA);
        tick(); chk("fim", ST_FIM, O_FIM);
        tick(); chk("fim_mantido", ST_FIM, O_FIM);
        iniciar = 1'b1; vidas = 1'b1;
        tick(); chk("reinicio", ST_PREPARA, O_PREPARA);
        tick(); chk("reinicio_unico", ST_ESPERA, O_NADA);
        iniciar = 1'b0;

        // Test 6: asynchronous reset in SALVA_X
        for (int i = 0; i < int'(PASSO) + 1; i++) tick();
        chk("pre_reset_salva_x", ST_SALVA_X, 11'b010_000_000_00);
        #2 reset = 1'b0;
        #1 chk("reset_async", ST_INICIAL, O_INICIAL);
        tick(); chk("reset_mantido", ST_INICIAL, O_INICIAL);
        reset = 1'b1;
        tick(); chk("pos_reset_idle", ST_INICIAL, O_INICIAL);

        // Step counter restarts clean after reset
        iniciar = 1'b1;
        tick(); iniciar = 1'b0;
        for (int i = 0; i < int'(PASSO); i++) tick();
        chk("espera_ultimo", ST_ESPERA, O_NADA);
        tick(); chk("calc_x_pos_reset", ST_CALC_X, O_NADA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
